// File: rtl/mux_nto1_scan_pkg.sv
// Shared constants and helpers for the N-to-1 scanning selector.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int wrap_inc(input int idx, input int nch);
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Channel bus plus valid/ready output stage of the scanning selector.
interface mux_nto1_scan_if #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in;
  logic [NCH-1:0]       ch_en;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in, ch_en, mode, sel, out_ready,
    input  out_data, out_sel, out_valid
  );

  modport slave (
    input  in, ch_en, mode, sel, out_ready,
    output out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_nto1_scan_chan_pick.sv
// Finds the first enabled channel at or after a start pointer, wrapping once.
module chan_pick #(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  ch_en_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            found_o,
  output logic [SELW-1:0] idx_o
);
  typedef logic [SELW:0] pos_t;
  localparam pos_t NCH_W = pos_t'(NCH);

  pos_t pos_s;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos_s   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      pos_s = {1'b0, ptr_i} + pos_t'(i);
      if (pos_s >= NCH_W) begin
        pos_s = pos_s - NCH_W;
      end else begin
        pos_s = pos_s;
      end
      if (ch_en_i[pos_s[SELW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos_s[SELW-1:0];
      end else begin
        found_o = found_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-channel selector with manual select, round-robin scan with
// dwell, per-channel enable mask and a valid/ready output register.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_nto1_scan_if.slave  bus
);
  localparam int SELW = $clog2(NCH);
  localparam int DCW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef logic [SELW-1:0] sel_t;
  typedef logic [SELW:0]   selx_t;
  typedef logic [DCW-1:0]  dcnt_t;

  localparam selx_t NCH_W = selx_t'(NCH);
  localparam dcnt_t DLAST = dcnt_t'(DWELL - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  sel_t             out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  sel_t             ptr_q, ptr_d;
  dcnt_t            dcnt_q, dcnt_d;
  logic             mode_q;

  logic  load_s;
  logic  scan_found_s;
  sel_t  scan_idx_s;
  logic  cand_ok_s;
  sel_t  cand_s;
  dcnt_t dcnt_eff_s;

  chan_pick #(.NCH(NCH)) u_pick (
    .ch_en_i (bus.ch_en),
    .ptr_i   (ptr_q),
    .found_o (scan_found_s),
    .idx_o   (scan_idx_s)
  );

  // Candidate channel for this cycle in the currently selected mode.
  always_comb begin
    cand_ok_s = 1'b0;
    cand_s    = '0;
    if (bus.mode == MODE_SCAN) begin
      cand_ok_s = scan_found_s;
      cand_s    = scan_idx_s;
    end else if ({1'b0, bus.sel} < NCH_W) begin
      cand_ok_s = bus.ch_en[bus.sel];
      cand_s    = bus.sel;
    end else begin
      cand_ok_s = 1'b0;
      cand_s    = bus.sel;
    end
  end

  assign load_s     = !out_valid_q || bus.out_ready;
  // A mode switch restarts the dwell even while the output is stalled.
  assign dcnt_eff_s = (bus.mode != mode_q) ? dcnt_t'(0) : dcnt_q;

  // Output register, scan pointer and dwell counter next-state.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_eff_s;
    if (load_s) begin
      if (cand_ok_s) begin
        out_data_d  = bus.in[cand_s*WIDTH +: WIDTH];
        out_sel_d   = cand_s;
        out_valid_d = 1'b1;
        if (bus.mode == MODE_SCAN) begin
          if (dcnt_eff_s == DLAST) begin
            dcnt_d = '0;
            ptr_d  = sel_t'(wrap_inc(int'(cand_s), NCH));
          end else begin
            dcnt_d = dcnt_eff_s + dcnt_t'(1);
          end
        end else begin
          dcnt_d = dcnt_eff_s;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      dcnt_q      <= '0;
      mode_q      <= MODE_MANUAL;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
      mode_q      <= bus.mode;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: directed scenarios plus randomized traffic checked
// against a behavioural model on three configurations.
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_nto1_scan_if #(.WIDTH(1), .NCH(4)) if4  ();
  mux_nto1_scan_if #(.WIDTH(1), .NCH(4)) if4d ();
  mux_nto1_scan_if #(.WIDTH(8), .NCH(3)) if3  ();

  mux_nto1_scan #(.WIDTH(1), .NCH(4), .DWELL(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  mux_nto1_scan #(.WIDTH(1), .NCH(4), .DWELL(2)) u4d (.clk(clk), .rst_n(rst_n), .bus(if4d.slave));
  mux_nto1_scan #(.WIDTH(8), .NCH(3), .DWELL(1)) u3  (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  typedef struct {
    int          ptr;
    int          dcnt;
    bit          mode_prev;
    logic [31:0] data;
    logic [31:0] sel;
    logic        valid;
  } mstate_t;

  mstate_t m4, m4d, m3;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.ptr = 0; s.dcnt = 0; s.mode_prev = 1'b0;
    s.data = 32'd0; s.sel = 32'd0; s.valid = 1'b0;
    return s;
  endfunction

  // One clock of the selector's rules: linear wrap-around search, modulo pointer.
  function automatic mstate_t model_step(mstate_t s, int nch, int w, int dwell,
                                         bit rdy, bit mode, int sel, int en,
                                         logic [31:0] inb);
    mstate_t n = s;
    int cand = -1;
    int d;
    bit load = !s.valid || rdy;
    if (!mode) begin
      if (sel < nch && en[sel]) cand = sel;
    end else begin
      for (int k = 0; k < nch; k++) begin
        int p = (s.ptr + k) % nch;
        if (cand < 0 && en[p]) cand = p;
      end
    end
    d = (mode != s.mode_prev) ? 0 : s.dcnt;
    n.mode_prev = mode;
    n.dcnt = d;
    if (load) begin
      if (cand >= 0) begin
        n.data  = (inb >> (cand * w)) & ((32'd1 << w) - 32'd1);
        n.sel   = cand;
        n.valid = 1'b1;
        if (mode) begin
          if (d + 1 == dwell) begin
            n.dcnt = 0;
            n.ptr  = (cand + 1) % nch;
          end else begin
            n.dcnt = d + 1;
          end
        end
      end else begin
        n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m4 <= model_reset();
    else m4 <= model_step(m4, 4, 1, 1, if4.out_ready, if4.mode, int'(if4.sel),
                          int'(if4.ch_en), 32'(if4.in));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m4d <= model_reset();
    else m4d <= model_step(m4d, 4, 1, 2, if4d.out_ready, if4d.mode, int'(if4d.sel),
                           int'(if4d.ch_en), 32'(if4d.in));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m3 <= model_reset();
    else m3 <= model_step(m3, 3, 8, 1, if3.out_ready, if3.mode, int'(if3.sel),
                          int'(if3.ch_en), 32'(if3.in));

  task automatic test_reset();
    @(negedge clk);
    n_checks += 3;
    if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b expected 0", if4.out_valid); end
    if (if4.out_sel !== 2'd0)   begin n_fail++; $display("FAIL reset_sel4: got %0d expected 0", if4.out_sel); end
    if (if4.out_data !== 1'b0)  begin n_fail++; $display("FAIL reset_data4: got %b expected 0", if4.out_data); end
    n_checks += 2;
    if (if4d.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4d: got %b expected 0", if4d.out_valid); end
    if (if3.out_data !== 8'd0)   begin n_fail++; $display("FAIL reset_data3: got %0h expected 0", if3.out_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [3:0] pat = 4'b1010;
    if4.in = pat; if4.ch_en = 4'hF; if4.mode = 1'b0; if4.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if4.sel = 2'(s);
      @(negedge clk);
      n_checks += 3;
      if (if4.out_data !== pat[s]) begin n_fail++; $display("FAIL manual_data[%0d]: got %b expected %b", s, if4.out_data, pat[s]); end
      if (if4.out_sel !== 2'(s))   begin n_fail++; $display("FAIL manual_sel[%0d]: got %0d expected %0d", s, if4.out_sel, s); end
      if (if4.out_valid !== 1'b1)  begin n_fail++; $display("FAIL manual_valid[%0d]: got %b expected 1", s, if4.out_valid); end
    end
  endtask

  task automatic test_scan();
    logic [3:0] pat = 4'b1010;
    int exp_d2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    if4.mode = 1'b1;
    if4d.in = pat; if4d.ch_en = 4'hF; if4d.mode = 1'b1; if4d.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) begin
        n_checks += 2;
        if (if4.out_sel !== 2'(i % 4)) begin n_fail++; $display("FAIL scan_sel[%0d]: got %0d expected %0d", i, if4.out_sel, i % 4); end
        if (if4.out_data !== pat[i % 4]) begin n_fail++; $display("FAIL scan_data[%0d]: got %b expected %b", i, if4.out_data, pat[i % 4]); end
        if (i == 7) if4.mode = 1'b0;
      end
      n_checks++;
      if (if4d.out_sel !== 2'(exp_d2[i])) begin n_fail++; $display("FAIL dwell2_sel[%0d]: got %0d expected %0d", i, if4d.out_sel, exp_d2[i]); end
    end
  endtask

  task automatic test_scan_mask();
    int exp_m [4] = '{0, 2, 0, 2};
    if4.mode = 1'b1; if4.ch_en = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (if4.out_sel !== 2'(exp_m[i])) begin n_fail++; $display("FAIL mask_sel[%0d]: got %0d expected %0d", i, if4.out_sel, exp_m[i]); end
    end
    if4.ch_en = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL mask_none_valid[%0d]: got %b expected 0", i, if4.out_valid); end
      if (if4.out_sel !== 2'd2)   begin n_fail++; $display("FAIL mask_none_hold[%0d]: got %0d expected 2", i, if4.out_sel); end
    end
    if4.ch_en = 4'b1000;
    @(negedge clk);
    n_checks += 2;
    if (if4.out_sel !== 2'd3)   begin n_fail++; $display("FAIL mask_reen_sel: got %0d expected 3", if4.out_sel); end
    if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL mask_reen_valid: got %b expected 1", if4.out_valid); end
  endtask

  task automatic test_backpressure();
    logic held;
    bit   found = 1'b0;
    if4.ch_en = 4'hF; if4.out_ready = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (if4.out_sel == 2'd1 && if4.out_valid == 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL bp_reach_sel1: got %0d expected 1 within 8 clocks", if4.out_sel);
    end else begin
      held = if4.out_data;
      if4.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if4.in = ~if4.in;
        @(negedge clk);
        n_checks += 3;
        if (if4.out_sel !== 2'd1)   begin n_fail++; $display("FAIL bp_sel[%0d]: got %0d expected 1", i, if4.out_sel); end
        if (if4.out_data !== held)  begin n_fail++; $display("FAIL bp_data[%0d]: got %b expected %b", i, if4.out_data, held); end
        if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, if4.out_valid); end
      end
      if4.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (if4.out_sel !== 2'd2) begin n_fail++; $display("FAIL bp_resume_sel: got %0d expected 2", if4.out_sel); end
    end
  endtask

  task automatic test_manual_disabled();
    logic [23:0] v = 24'($urandom);
    if4.mode = 1'b0; if4.sel = 2'd2; if4.ch_en = 4'b1011;
    if3.mode = 1'b0; if3.sel = 2'd3; if3.ch_en = 3'b111; if3.out_ready = 1'b1; if3.in = v;
    @(negedge clk);
    n_checks += 2;
    if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL man_dis_valid4: got %b expected 0", if4.out_valid); end
    if (if3.out_valid !== 1'b0) begin n_fail++; $display("FAIL man_range_valid3: got %b expected 0", if3.out_valid); end
    if3.sel = 2'd2;
    @(negedge clk);
    n_checks += 3;
    if (if3.out_valid !== 1'b1)     begin n_fail++; $display("FAIL man3_valid: got %b expected 1", if3.out_valid); end
    if (if3.out_sel !== 2'd2)       begin n_fail++; $display("FAIL man3_sel: got %0d expected 2", if3.out_sel); end
    if (if3.out_data !== v[23:16])  begin n_fail++; $display("FAIL man3_data: got %0h expected %0h", if3.out_data, v[23:16]); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    if4.in = 4'b1010; if4.ch_en = 4'hF; if4.mode = 1'b1; if4.out_ready = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (if4.out_sel == 2'd2 && if4.out_valid == 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_reach_sel2: got %0d expected 2 within 8 clocks", if4.out_sel); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", if4.out_valid); end
    if (if4.out_sel !== 2'd0)   begin n_fail++; $display("FAIL rst_mid_sel: got %0d expected 0", if4.out_sel); end
    if (if4.out_data !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_data: got %b expected 0", if4.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (if4.out_sel !== 2'(i))  begin n_fail++; $display("FAIL rst_restart_sel[%0d]: got %0d expected %0d", i, if4.out_sel, i); end
      if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_restart_valid[%0d]: got %b expected 1", i, if4.out_valid); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) if4.mode  = ~if4.mode;
      if ($urandom_range(0, 15) == 0) if4d.mode = ~if4d.mode;
      if ($urandom_range(0, 15) == 0) if3.mode  = ~if3.mode;
      if4.sel  = 2'($urandom_range(0, 3)); if4d.sel = 2'($urandom_range(0, 3)); if3.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) if4.ch_en  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) if4d.ch_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) if3.ch_en  = 3'($urandom);
      if4.in = 4'($urandom); if4d.in = 4'($urandom); if3.in = 24'($urandom);
      if4.out_ready  = ($urandom_range(0, 3) != 0);
      if4d.out_ready = ($urandom_range(0, 3) != 0);
      if3.out_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_checks += 9;
      if (if4.out_valid !== m4.valid)          begin n_fail++; $display("FAIL rnd4_valid@%0d: got %b expected %b", c, if4.out_valid, m4.valid); end
      if (32'(if4.out_sel) !== m4.sel)         begin n_fail++; $display("FAIL rnd4_sel@%0d: got %0d expected %0d", c, if4.out_sel, m4.sel); end
      if (32'(if4.out_data) !== m4.data)       begin n_fail++; $display("FAIL rnd4_data@%0d: got %0h expected %0h", c, if4.out_data, m4.data); end
      if (if4d.out_valid !== m4d.valid)        begin n_fail++; $display("FAIL rnd4d_valid@%0d: got %b expected %b", c, if4d.out_valid, m4d.valid); end
      if (32'(if4d.out_sel) !== m4d.sel)       begin n_fail++; $display("FAIL rnd4d_sel@%0d: got %0d expected %0d", c, if4d.out_sel, m4d.sel); end
      if (32'(if4d.out_data) !== m4d.data)     begin n_fail++; $display("FAIL rnd4d_data@%0d: got %0h expected %0h", c, if4d.out_data, m4d.data); end
      if (if3.out_valid !== m3.valid)          begin n_fail++; $display("FAIL rnd3_valid@%0d: got %b expected %b", c, if3.out_valid, m3.valid); end
      if (32'(if3.out_sel) !== m3.sel)         begin n_fail++; $display("FAIL rnd3_sel@%0d: got %0d expected %0d", c, if3.out_sel, m3.sel); end
      if (32'(if3.out_data) !== m3.data)       begin n_fail++; $display("FAIL rnd3_data@%0d: got %0h expected %0h", c, if3.out_data, m3.data); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if4.in  = '0; if4.ch_en  = '0; if4.mode  = 1'b0; if4.sel  = '0; if4.out_ready  = 1'b1;
    if4d.in = '0; if4d.ch_en = '0; if4d.mode = 1'b0; if4d.sel = '0; if4d.out_ready = 1'b1;
    if3.in  = '0; if3.ch_en  = '0; if3.mode  = 1'b0; if3.sel  = '0; if3.out_ready  = 1'b1;
    @(negedge clk);
    test_reset();
    test_manual();
    test_scan();
    test_scan_mask();
    test_backpressure();
    test_manual_disabled();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
